shift_reg_univ: RTL and testbench
=================================

// Module: shift_reg_univ
// PURPOSE
//  Parametrised universal shift register, successor to shift_reg. Adds wider data,
//  multi-bit steps, logical/arithmetic/rotate modes and parallel load. Adds a burst
//  sequencer that performs N back-to-back shifts from a single start strobe. Used
//  as a general serialiser/deserialiser and bit-manipulation stage in the datapath.
// PARAMETERS
//  WIDTH    16   register width in bits; must be >= 2
//  STEP     1    bits moved per shift/rotate operation; range 1..WIDTH-1
//  CNT_W    $clog2(WIDTH+1)   derived localparam; width of burst_len and counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rstn       in   1      asynchronous, active-high reset (1 = reset)
//  en         in   1      enables manual operation in IDLE; ignored during a burst
//  mode       in   3      000 HOLD, 001 SHL, 010 SHR, 011 SAR, 100 ROL, 101 ROR, 110 LOAD, 111 CLEAR
//  sin_l      in   STEP   serial in for SHL; enters out[STEP-1:0]
//  sin_r      in   STEP   serial in for SHR; enters out[WIDTH-1 -: STEP]
//  pdata      in   WIDTH  parallel load data for LOAD
//  start      in   1      starts a burst of burst_len ops using mode
//  burst_len  in   CNT_W  number of ops in a burst
//  out        out  WIDTH  register contents
//  sout_l     out  STEP   combinational out[WIDTH-1 -: STEP]; bits lost on the next SHL
//  sout_r     out  STEP   combinational out[STEP-1:0]; bits lost on the next SHR/SAR
//  busy       out  1      1 while in RUN
//  done       out  1      one-cycle pulse when a burst ends
// BEHAVIOUR
//  Reset (async, immediate): out=0, busy=0, done=0, state=IDLE, counter=0.
//   A reset mid-burst aborts the burst and done is not pulsed.
//  Op semantics per edge, STEP bits per op:
//   SHL:  out <= {out[WIDTH-STEP-1:0], sin_l}
//   SHR:  out <= {sin_r, out[WIDTH-1:STEP]}
//   SAR:  fills with STEP copies of out[WIDTH-1]; sin_r is ignored.
//   ROL/ROR: rotate by STEP; sin_* are ignored.
//   LOAD: out <= pdata.  CLEAR: out <= 0.  HOLD: out is unchanged.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - If start=1 with mode in 001..101 and burst_len!=0: latch mode and burst_len.
//     Go to RUN; no op is applied on this edge. start has priority over en.
//   - If start=1 with mode in {000,110,111} or burst_len=0: go to DONE.
//     out is unchanged.
//   - Else if en=1: apply mode on this edge. Else hold.
//  RUN:
//   - busy=1. Apply the latched mode once per edge.
//   - sin_l/sin_r are sampled live each edge.
//   - en, start and mode inputs are ignored.
//   - After the burst_len-th op, go to DONE.
//  DONE: one cycle. done=1, busy=0, out held, start and en ignored. Then go to IDLE.
//  Timing: start sampled at edge 0 -> ops at edges 1..N -> done high between
//   edges N and N+1 -> IDLE after edge N+1. Minimum start-to-start spacing is N+2 cycles.
//  Outputs: busy and done are registered (decoded from the state flops).
//   sout_l and sout_r are combinational from out.
// STRUCTURE
//  shift_reg_pkg:
//   - mode localparams/enum (MODE_HOLD..MODE_CLEAR)
//   - FSM state enum (ST_IDLE, ST_RUN, ST_DONE)
//   - function is_shift_mode()
//  Sub-module shift_step:
//   - combinational next-value for one op
//   - params WIDTH, STEP; inputs cur, mode, sin_l, sin_r, pdata; output nxt
//   - instanced once and shared by the manual and burst paths
//  Top level holds the out register, the FSM and the down-counter.
// TESTING  (WIDTH=16, STEP=1 unless noted)
//  1. Hold rstn=1 for 2 clk, release; assert rstn mid-cycle later.
//     -> out=0000, busy=0, done=0 immediately, without waiting for a clock edge.
//  2. LOAD pdata=A5C3, then SHL with sin_l=1 for 4 clocks.
//     -> out=5C3F; sout_l sequence 1,0,1,0.
//  3. LOAD 8001: SAR -> C000; ROR of 0001 -> 8000; ROL of 8000 -> 0001.
//     SHR of 8001 with sin_r=0 -> 4000. en=0 holds out in every case.
//  4. LOAD 00FF, start with mode=ROL, burst_len=4, en toggling during the burst.
//     -> busy high 4 cycles; out=0FF0; done single pulse on the 5th cycle.
//     -> start and en during RUN have no effect.
//  5. Same burst, rstn pulsed after 2 ops.
//     -> out=0000, busy=0, no done pulse; a new start after release works normally.
//  6. WIDTH=16, STEP=4: LOAD 1234, SHL sin_l=F -> 234F; SAR of 8000 -> F800.
//     start with burst_len=0 -> out unchanged, busy stays 0, done pulses next cycle.

Source files
------------

// File: rtl/shift_reg_univ_pkg.sv
// Shared constants for the universal shift register.
//   - MODE_*     : 3-bit operation codes presented on the mode input
//   - ST_*       : burst sequencer state encodings
//   - is_shift_mode(): true for modes that a burst may repeat (SHL..ROR)
package shift_reg_univ_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_SAR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bursts only make sense for ops that move bits; HOLD/LOAD/CLEAR repeated
  // N times is the same as doing them once.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle between a requester and shift_reg_univ.
//   master: drives en, mode, sin_l, sin_r, pdata, start, burst_len;
//           observes out, sout_l, sout_r, busy, done
//   slave : the mirror image, used by shift_reg_univ
interface shift_reg_univ_if #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic [STEP-1:0]  sin_l;
  logic [STEP-1:0]  sin_r;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] out;
  logic [STEP-1:0]  sout_l;
  logic [STEP-1:0]  sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin_l, sin_r, pdata, start, burst_len,
    input  out, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, mode, sin_l, sin_r, pdata, start, burst_len,
    output out, sout_l, sout_r, busy, done
  );

endinterface

// File: rtl/shift_reg_univ_step.sv
// Combinational next-value for a single register operation.
//   cur   : current register value
//   mode  : operation code (MODE_*)
//   sin_l : bits entering the low end on SHL
//   sin_r : bits entering the high end on SHR
//   pdata : value taken on LOAD
//   nxt   : resulting register value
module shift_step
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic [STEP-1:0]  sin_l,
  input  logic [STEP-1:0]  sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] nxt
);

  // Select the result of one STEP-bit operation.
  always_comb begin
    nxt = cur;
    case (mode)
      MODE_HOLD:  nxt = cur;
      MODE_SHL:   nxt = {cur[WIDTH-STEP-1:0], sin_l};
      MODE_SHR:   nxt = {sin_r, cur[WIDTH-1:STEP]};
      MODE_SAR:   nxt = {{STEP{cur[WIDTH-1]}}, cur[WIDTH-1:STEP]};
      MODE_ROL:   nxt = {cur[WIDTH-STEP-1:0], cur[WIDTH-1 -: STEP]};
      MODE_ROR:   nxt = {cur[STEP-1:0], cur[WIDTH-1:STEP]};
      MODE_LOAD:  nxt = pdata;
      MODE_CLEAR: nxt = {WIDTH{1'b0}};
      default:    nxt = cur;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with a burst sequencer.
//   clk  : clock, all state on posedge
//   rstn : asynchronous reset, active HIGH despite the name (kept for
//          compatibility with the shift_reg it replaces)
//   bus  : shift_reg_univ_if.slave - controls in, out/sout_l/sout_r/busy/done out
// In IDLE the register follows mode when en=1. A start strobe with a shift
// mode and nonzero burst_len runs burst_len back-to-back ops in RUN, then
// spends one cycle in DONE. Anything else on start goes straight to DONE.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           rstn,
  shift_reg_univ_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] nxt_s;
  logic [1:0]       state_r;
  logic [2:0]       mode_r;
  logic [2:0]       op_mode_s;
  logic [CNT_W-1:0] cnt_r;

  // During a burst the latched mode drives the datapath; the live mode input
  // is only honoured in IDLE.
  always_comb begin
    if (state_r == ST_RUN) begin
      op_mode_s = mode_r;
    end else begin
      op_mode_s = bus.mode;
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .cur   (out_r),
    .mode  (op_mode_s),
    .sin_l (bus.sin_l),
    .sin_r (bus.sin_r),
    .pdata (bus.pdata),
    .nxt   (nxt_s)
  );

  // Register, sequencer state and burst down-counter.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_r   <= {WIDTH{1'b0}};
      state_r <= ST_IDLE;
      mode_r  <= MODE_HOLD;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // start wins over en; the launching edge itself applies no op
          if (bus.start) begin
            if (is_shift_mode(bus.mode) && (bus.burst_len != CNT_ZERO)) begin
              mode_r  <= bus.mode;
              cnt_r   <= bus.burst_len;
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_DONE;
            end
          end else if (bus.en) begin
            out_r <= nxt_s;
          end else begin
            out_r <= out_r;
          end
        end
        ST_RUN: begin
          out_r <= nxt_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // busy/done decode straight from the state flops, so no combinational
  // path from inputs reaches them.
  assign bus.out    = out_r;
  assign bus.busy   = (state_r == ST_RUN);
  assign bus.done   = (state_r == ST_DONE);
  assign bus.sout_l = out_r[WIDTH-1 -: STEP];
  assign bus.sout_r = out_r[STEP-1:0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: one STEP=1 and one STEP=4 instance.
// Expected {busy,done,out} words are queued as each cycle's stimulus is
// applied and popped/compared one clock later.
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  shift_reg_univ_if #(.WIDTH(16), .STEP(1)) b1 ();
  shift_reg_univ_if #(.WIDTH(16), .STEP(4)) b4 ();

  shift_reg_univ #(.WIDTH(16), .STEP(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1.slave));
  shift_reg_univ #(.WIDTH(16), .STEP(4)) dut4 (.clk(clk), .rstn(rstn), .bus(b4.slave));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [15:0] o, input logic b, input logic d);
    return {14'd0, b, d, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation, clock once, then pop and compare.
  task automatic step1(input string tag, input logic [15:0] o, input logic b, input logic d);
    exp_t e;
    sb.push_back('{tag, pk(o, b, d)});
    tick();
    e = sb.pop_front();
    chk(e.tag, pk(b1.out, b1.busy, b1.done), e.val);
  endtask

  task automatic step4(input string tag, input logic [15:0] o, input logic b, input logic d);
    exp_t e;
    sb.push_back('{tag, pk(o, b, d)});
    tick();
    e = sb.pop_front();
    chk(e.tag, pk(b4.out, b4.busy, b4.done), e.val);
  endtask

  task automatic drv1(input logic e, input logic [2:0] m, input logic sl, input logic sr,
                      input logic [15:0] pd, input logic st, input logic [4:0] bl);
    b1.en = e; b1.mode = m; b1.sin_l = sl; b1.sin_r = sr;
    b1.pdata = pd; b1.start = st; b1.burst_len = bl;
  endtask

  task automatic drv4(input logic e, input logic [2:0] m, input logic [3:0] sl, input logic [3:0] sr,
                      input logic [15:0] pd, input logic st, input logic [4:0] bl);
    b4.en = e; b4.mode = m; b4.sin_l = sl; b4.sin_r = sr;
    b4.pdata = pd; b4.start = st; b4.burst_len = bl;
  endtask

  logic [15:0] shl_exp [4] = '{16'h4B87, 16'h970F, 16'h2E1F, 16'h5C3F};
  logic        shl_so  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  t3_mode [6] = '{MODE_SAR, MODE_ROR, MODE_ROL, MODE_SHR, MODE_CLEAR, MODE_HOLD};
  logic [15:0] t3_load [6] = '{16'h8001, 16'h0001, 16'h8000, 16'h8001, 16'h8001, 16'h8001};
  logic [15:0] t3_exp  [6] = '{16'hC000, 16'h8000, 16'h0001, 16'h4000, 16'h0000, 16'h8001};
  logic [15:0] b_out   [4] = '{16'h01FE, 16'h03FC, 16'h07F8, 16'h0FF0};
  logic        b_busy  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic        b_done  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset held for two clocks
    rstn = 1'b1;
    drv1(1'b0, MODE_HOLD, 1'b0, 1'b0, 16'h0000, 1'b0, 5'd0);
    drv4(1'b0, MODE_HOLD, 4'h0, 4'h0, 16'h0000, 1'b0, 5'd0);
    repeat (2) tick();
    chk("rst_dut1", pk(b1.out, b1.busy, b1.done), pk(16'h0000, 1'b0, 1'b0));
    chk("rst_dut4", pk(b4.out, b4.busy, b4.done), pk(16'h0000, 1'b0, 1'b0));
    rstn = 1'b0;

    // LOAD A5C3 then four SHL with sin_l=1
    drv1(1'b1, MODE_LOAD, 1'b0, 1'b0, 16'hA5C3, 1'b0, 5'd0);
    step1("load_a5c3", 16'hA5C3, 1'b0, 1'b0);
    drv1(1'b1, MODE_SHL, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("shl_sout_l%0d", i), {31'd0, b1.sout_l}, {31'd0, shl_so[i]});
      step1($sformatf("shl%0d", i), shl_exp[i], 1'b0, 1'b0);
    end
    b1.en = 1'b0;
    step1("shl_hold", 16'h5C3F, 1'b0, 1'b0);

    // Single ops from a known load, each followed by an en=0 hold
    for (int i = 0; i < 6; i++) begin
      drv1(1'b1, MODE_LOAD, 1'b1, 1'b1, t3_load[i], 1'b0, 5'd0);
      step1($sformatf("t3_load%0d", i), t3_load[i], 1'b0, 1'b0);
      if (i == 0) chk("sout_r_8001", {31'd0, b1.sout_r}, 32'd1);
      drv1(1'b1, t3_mode[i], 1'b1, (t3_mode[i] == MODE_SHR) ? 1'b0 : 1'b1, 16'hFFFF, 1'b0, 5'd0);
      step1($sformatf("t3_op%0d", i), t3_exp[i], 1'b0, 1'b0);
      b1.en = 1'b0;
      step1($sformatf("t3_hold%0d", i), t3_exp[i], 1'b0, 1'b0);
    end

    // Asynchronous reset asserted mid-cycle takes effect at once
    #3 rstn = 1'b1;
    #1 chk("async_rst", pk(b1.out, b1.busy, b1.done), pk(16'h0000, 1'b0, 1'b0));
    @(negedge clk) rstn = 1'b0;

    // Burst: ROL x4 from 00FF; inputs changed during RUN/DONE must not matter
    drv1(1'b1, MODE_LOAD, 1'b0, 1'b0, 16'h00FF, 1'b0, 5'd0);
    step1("b_load", 16'h00FF, 1'b0, 1'b0);
    drv1(1'b0, MODE_ROL, 1'b0, 1'b0, 16'h00FF, 1'b1, 5'd4);
    step1("b_start", 16'h00FF, 1'b1, 1'b0);
    drv1(1'b0, MODE_LOAD, 1'b1, 1'b1, 16'hFFFF, 1'b1, 5'd7);
    for (int i = 0; i < 4; i++) begin
      b1.en = i[0];
      step1($sformatf("b_op%0d", i), b_out[i], b_busy[i], b_done[i]);
    end
    b1.en = 1'b1;
    step1("b_after_done", 16'h0FF0, 1'b0, 1'b0);
    drv1(1'b0, MODE_HOLD, 1'b0, 1'b0, 16'h0000, 1'b0, 5'd0);
    step1("b_idle", 16'h0FF0, 1'b0, 1'b0);

    // Burst aborted by reset after two ops
    drv1(1'b1, MODE_LOAD, 1'b0, 1'b0, 16'h00FF, 1'b0, 5'd0);
    step1("a_load", 16'h00FF, 1'b0, 1'b0);
    drv1(1'b0, MODE_ROL, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd4);
    step1("a_start", 16'h00FF, 1'b1, 1'b0);
    b1.start = 1'b0;
    step1("a_op0", 16'h01FE, 1'b1, 1'b0);
    step1("a_op1", 16'h03FC, 1'b1, 1'b0);
    #3 rstn = 1'b1;
    #1 chk("a_rst_now", pk(b1.out, b1.busy, b1.done), pk(16'h0000, 1'b0, 1'b0));
    step1("a_rst_held", 16'h0000, 1'b0, 1'b0);
    @(negedge clk) rstn = 1'b0;
    drv1(1'b1, MODE_LOAD, 1'b0, 1'b0, 16'h00FF, 1'b0, 5'd0);
    step1("r_load", 16'h00FF, 1'b0, 1'b0);
    drv1(1'b0, MODE_ROL, 1'b0, 1'b0, 16'h0000, 1'b1, 5'd2);
    step1("r_start", 16'h00FF, 1'b1, 1'b0);
    b1.start = 1'b0;
    step1("r_op0", 16'h01FE, 1'b1, 1'b0);
    step1("r_op1", 16'h03FC, 1'b0, 1'b1);
    step1("r_idle", 16'h03FC, 1'b0, 1'b0);

    // start with a non-shift mode goes straight to DONE without touching out
    drv1(1'b1, MODE_LOAD, 1'b0, 1'b0, 16'h1111, 1'b1, 5'd3);
    step1("nl_start", 16'h03FC, 1'b0, 1'b1);
    drv1(1'b0, MODE_HOLD, 1'b0, 1'b0, 16'h0000, 1'b0, 5'd0);
    step1("nl_idle", 16'h03FC, 1'b0, 1'b0);

    // STEP=4 instance
    drv4(1'b1, MODE_LOAD, 4'h0, 4'h0, 16'h1234, 1'b0, 5'd0);
    step4("s4_load", 16'h1234, 1'b0, 1'b0);
    chk("s4_sout_l", {28'd0, b4.sout_l}, 32'h1);
    chk("s4_sout_r", {28'd0, b4.sout_r}, 32'h4);
    drv4(1'b1, MODE_SHL, 4'hF, 4'h0, 16'h0000, 1'b0, 5'd0);
    step4("s4_shl", 16'h234F, 1'b0, 1'b0);
    drv4(1'b1, MODE_LOAD, 4'h0, 4'h0, 16'h8000, 1'b0, 5'd0);
    step4("s4_load8000", 16'h8000, 1'b0, 1'b0);
    drv4(1'b1, MODE_SAR, 4'h0, 4'h5, 16'h0000, 1'b0, 5'd0);
    step4("s4_sar", 16'hF800, 1'b0, 1'b0);
    drv4(1'b1, MODE_SHL, 4'hA, 4'h0, 16'h0000, 1'b1, 5'd0);
    step4("s4_len0", 16'hF800, 1'b0, 1'b1);
    drv4(1'b0, MODE_HOLD, 4'h0, 4'h0, 16'h0000, 1'b0, 5'd0);
    step4("s4_len0_idle", 16'hF800, 1'b0, 1'b0);
    drv4(1'b0, MODE_ROL, 4'h0, 4'h0, 16'h0000, 1'b1, 5'd2);
    step4("s4_b_start", 16'hF800, 1'b1, 1'b0);
    b4.start = 1'b0;
    step4("s4_b_op0", 16'h800F, 1'b1, 1'b0);
    step4("s4_b_op1", 16'h00F8, 1'b0, 1'b1);
    step4("s4_b_idle", 16'h00F8, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
